// File: rtl/apb_reg_bridge_pkg.sv
// Shared types and constants for the APB-to-register bridge.
//   state_t     : bridge FSM state encoding
//   *_OFS       : byte offsets of the four registers from the register window base
//   reg_idx_w() : width of a register index for a given register count
package apb_reg_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [11:0] STATUS_OFS   = 12'h000;
    localparam logic [11:0] CONTROL_OFS  = 12'h004;
    localparam logic [11:0] IO_ADDR_OFS  = 12'h008;
    localparam logic [11:0] MEM_ADDR_OFS = 12'h00C;

    // Never narrower than one bit, so a single-register window still has an index port.
    function automatic int reg_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_reg_bridge_decode.sv
// Register window decoder (purely combinational).
//   paddr_i : APB byte address
//   hit_o   : address is word-aligned and inside [BASE_ADDR, BASE_ADDR + 4*NUM_REGS - 1]
//   index_o : register number (meaningful only when hit_o = 1)
module apb_reg_bridge_decode
    import apb_reg_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h400,
    parameter int                    NUM_REGS   = 4,
    parameter int                    IDX_W      = reg_idx_w(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    output logic                  hit_o,
    output logic [IDX_W-1:0]      index_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = BASE_ADDR + ADDR_WIDTH'(4 * NUM_REGS - 1);

    always_comb begin
        hit_o   = (paddr_i >= BASE_ADDR) && (paddr_i <= LAST_ADDR) && (paddr_i[1:0] == 2'b00);
        index_o = IDX_W'((paddr_i - BASE_ADDR) >> 2);
    end

endmodule

// File: rtl/apb_reg_bridge.sv
// APB3 slave front-end for the four-register block.
// Turns APB setup/access phases into single-cycle register-port accesses,
// inserts wait states, and flags out-of-window or misaligned accesses with pslverr.
//
// Optional build macro: REG_BRIDGE_STATS_EN adds saturating transfer counters.
//
// Ports
//   clk, reset        : clock; asynchronous active-high reset
//   psel_i, penable_i : APB select / access phase
//   pwrite_i          : 1 = write, 0 = read
//   paddr_i, pwdata_i : APB byte address / write data
//   prdata_o          : read data, holds until the next successful read
//   pready_o          : one-cycle transfer-complete pulse
//   pslverr_o         : decode error, valid with pready_o
//   reg_addr_o        : register block address (0 when no access is in progress)
//   reg_wr_en_o       : single-cycle write strobe
//   reg_wdata_o       : register block write data
//   reg_rdata_i       : register block read data, one cycle after the address
//   stat_*_cnt_o      : write/read/error counters (REG_BRIDGE_STATS_EN only)
//
// state | meaning
// IDLE  | no transfer; waits for an APB setup phase
// REQ   | register address driven; write strobe issued here for writes
// CAPT  | read only: register block returns data, captured into prdata
// RESP  | pready high for one cycle, pslverr reports the decode result
module apb_reg_bridge
    import apb_reg_bridge_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h400,
    parameter int                    NUM_REGS   = 4
`ifdef REG_BRIDGE_STATS_EN
    ,
    parameter int                    CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [ADDR_WIDTH-1:0] reg_addr_o,
    output logic                  reg_wr_en_o,
    output logic [DATA_WIDTH-1:0] reg_wdata_o,
    input  logic [DATA_WIDTH-1:0] reg_rdata_i
`ifdef REG_BRIDGE_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  stat_wr_cnt_o,
    output logic [CNT_WIDTH-1:0]  stat_rd_cnt_o,
    output logic [CNT_WIDTH-1:0]  stat_err_cnt_o
`endif
);

    localparam int IDX_W = reg_idx_w(NUM_REGS);

    state_t                state_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] prdata_q;
    logic                  pready_q;
    logic                  pslverr_q;
    logic [ADDR_WIDTH-1:0] reg_addr_q;
    logic                  reg_wr_en_q;
    logic [DATA_WIDTH-1:0] reg_wdata_q;

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_index;

    apb_reg_bridge_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_decode (
        .paddr_i    (paddr_i),
        .hit_o      (dec_hit),
        .index_o    (dec_index)
    );

`ifdef REG_BRIDGE_STATS_EN
    logic [CNT_WIDTH-1:0] stat_wr_cnt_q;
    logic [CNT_WIDTH-1:0] stat_rd_cnt_q;
    logic [CNT_WIDTH-1:0] stat_err_cnt_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            reg_addr_q  <= '0;
            reg_wr_en_q <= 1'b0;
            reg_wdata_q <= '0;
`ifdef REG_BRIDGE_STATS_EN
            stat_wr_cnt_q  <= '0;
            stat_rd_cnt_q  <= '0;
            stat_err_cnt_q <= '0;
`endif
        end else begin
            // Strobe and response flags are single-cycle pulses unless set below.
            reg_wr_en_q <= 1'b0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        wr_q <= pwrite_i;
                        if (dec_hit) begin
                            state_q     <= REQ;
                            // Rebuilt from the index: identical to paddr for any hit.
                            reg_addr_q  <= BASE_ADDR + ADDR_WIDTH'({dec_index, 2'b00});
                            reg_wr_en_q <= pwrite_i;
                            if (pwrite_i) begin
                                reg_wdata_q <= pwdata_i;
                            end
                        end else begin
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
`ifdef REG_BRIDGE_STATS_EN
                            if (stat_err_cnt_q != '1) stat_err_cnt_q <= stat_err_cnt_q + 1'b1;
`endif
                        end
                    end
                end

                REQ: begin
                    if (!psel_i) begin
                        // Master abandoned the transfer; a write strobe already issued stands.
                        state_q    <= IDLE;
                        reg_addr_q <= '0;
                    end else if (wr_q) begin
                        state_q    <= RESP;
                        pready_q   <= 1'b1;
                        reg_addr_q <= '0;
`ifdef REG_BRIDGE_STATS_EN
                        if (stat_wr_cnt_q != '1) stat_wr_cnt_q <= stat_wr_cnt_q + 1'b1;
`endif
                    end else begin
                        state_q <= CAPT;
                    end
                end

                CAPT: begin
                    if (!psel_i) begin
                        state_q    <= IDLE;
                        reg_addr_q <= '0;
                    end else begin
                        state_q    <= RESP;
                        prdata_q   <= reg_rdata_i;
                        pready_q   <= 1'b1;
                        reg_addr_q <= '0;
`ifdef REG_BRIDGE_STATS_EN
                        if (stat_rd_cnt_q != '1) stat_rd_cnt_q <= stat_rd_cnt_q + 1'b1;
`endif
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q    <= IDLE;
                    reg_addr_q <= '0;
                end
            endcase
        end
    end

    assign prdata_o    = prdata_q;
    assign pready_o    = pready_q;
    assign pslverr_o   = pslverr_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wr_en_o = reg_wr_en_q;
    assign reg_wdata_o = reg_wdata_q;

`ifdef REG_BRIDGE_STATS_EN
    assign stat_wr_cnt_o  = stat_wr_cnt_q;
    assign stat_rd_cnt_o  = stat_rd_cnt_q;
    assign stat_err_cnt_o = stat_err_cnt_q;
`endif

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Directed bench for apb_reg_bridge with a behavioural four-register block attached.
// Expected APB responses are queued as each transfer is launched and popped when
// pready is observed.
module tb_apb_reg_bridge;
    import apb_reg_bridge_pkg::*;

    localparam logic [31:0] BASE = 32'h400;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [31:0] reg_addr;
    logic        reg_wr_en;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
`ifdef REG_BRIDGE_STATS_EN
    logic [1:0]  stat_wr, stat_rd, stat_err;
`endif

    always #5 clk = ~clk;

    apb_reg_bridge #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (32'h400),
        .NUM_REGS   (4)
`ifdef REG_BRIDGE_STATS_EN
        ,
        .CNT_WIDTH  (2)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .psel_i      (psel),
        .penable_i   (penable),
        .pwrite_i    (pwrite),
        .paddr_i     (paddr),
        .pwdata_i    (pwdata),
        .prdata_o    (prdata),
        .pready_o    (pready),
        .pslverr_o   (pslverr),
        .reg_addr_o  (reg_addr),
        .reg_wr_en_o (reg_wr_en),
        .reg_wdata_o (reg_wdata),
        .reg_rdata_i (reg_rdata)
`ifdef REG_BRIDGE_STATS_EN
        ,
        .stat_wr_cnt_o  (stat_wr),
        .stat_rd_cnt_o  (stat_rd),
        .stat_err_cnt_o (stat_err)
`endif
    );

    // Register block model: writes on the strobe, otherwise reads the addressed
    // register with one cycle of latency.
    logic [31:0] regs [4];
    int          wr_strobes;
    int          multi_strobe;
    logic        prev_wr_en;
    logic [31:0] last_wr_addr, last_wr_data;

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h10) && (a[1:0] == 2'b00);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            reg_rdata <= '0;
        end else if (reg_wr_en) begin
            if (in_win(reg_addr)) regs[(reg_addr - BASE) >> 2] <= reg_wdata;
        end else begin
            reg_rdata <= in_win(reg_addr) ? regs[(reg_addr - BASE) >> 2] : 32'h0;
        end
    end

    always @(posedge clk) begin
        if (reg_wr_en) begin
            wr_strobes   = wr_strobes + 1;
            last_wr_addr = reg_addr;
            last_wr_data = reg_wdata;
            if (prev_wr_en) multi_strobe = multi_strobe + 1;
        end
        prev_wr_en = reg_wr_en;
    end

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One APB transfer; returns one cycle after completion with the bus released,
    // so a following call gives a back-to-back setup phase.
    task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic err,
                            input logic [31:0] exp_rd);
        exp_t e;
        exp_t got;
        int   lat;
        e.tag   = tag;
        e.err   = err;
        e.lat   = err ? 1 : (wr ? 2 : 3);
        if (!wr && !err) last_rd = exp_rd;
        e.rdata = last_rd;
        sb.push_back(e);

        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 1;
        while (!pready && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        got = sb.pop_front();
        check({got.tag, ".pready"},  {31'b0, pready},  32'd1);
        check({got.tag, ".latency"}, lat,             got.lat);
        check({got.tag, ".pslverr"}, {31'b0, pslverr}, {31'b0, got.err});
        check({got.tag, ".prdata"},  prdata,          got.rdata);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        check({got.tag, ".pready_drop"}, {31'b0, pready}, 32'd0);
    endtask

    int          s0;
    logic        saw_ready;

    initial begin
        wr_strobes = 0; multi_strobe = 0; prev_wr_en = 1'b0;
        last_wr_addr = '0; last_wr_data = '0; last_rd = '0;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.prdata",    prdata,              32'h0);
        check("rst.pready",    {31'b0, pready},     32'h0);
        check("rst.pslverr",   {31'b0, pslverr},    32'h0);
        check("rst.reg_addr",  reg_addr,            32'h0);
        check("rst.reg_wr_en", {31'b0, reg_wr_en},  32'h0);
        check("rst.reg_wdata", reg_wdata,           32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Write to CONTROL
        s0 = wr_strobes;
        apb_xfer("t1.wr", 1'b1, BASE + 32'(CONTROL_OFS), 32'hDEAD_BEEF, 1'b0, 32'h0);
        check("t1.strobes",  wr_strobes - s0, 1);
        check("t1.wr_addr",  last_wr_addr,    32'h404);
        check("t1.wr_data",  last_wr_data,    32'hDEAD_BEEF);
        check("t1.idle_addr", reg_addr,       32'h0);

        // Read it back
        apb_xfer("t2.rd", 1'b0, 32'h404, 32'h0, 1'b0, 32'hDEAD_BEEF);

        // Out-of-window write and misaligned read: no register access
        s0 = wr_strobes;
        apb_xfer("t3.oow", 1'b1, 32'h410, 32'h1234_5678, 1'b1, 32'h0);
        apb_xfer("t3.mis", 1'b0, 32'h402, 32'h0,         1'b1, 32'h0);
        check("t3.strobes", wr_strobes - s0, 0);
        check("t3.reg1",    regs[1],         32'hDEAD_BEEF);
        check("t3.reg0",    regs[0],         32'h0);

        // Back-to-back writes then reads
        s0 = wr_strobes;
        apb_xfer("t4.w0", 1'b1, BASE + 32'(STATUS_OFS),   32'h1, 1'b0, 32'h0);
        apb_xfer("t4.w2", 1'b1, BASE + 32'(IO_ADDR_OFS),  32'h2, 1'b0, 32'h0);
        apb_xfer("t4.w3", 1'b1, BASE + 32'(MEM_ADDR_OFS), 32'h3, 1'b0, 32'h0);
        apb_xfer("t4.r0", 1'b0, 32'h400, 32'h0, 1'b0, 32'h1);
        apb_xfer("t4.r2", 1'b0, 32'h408, 32'h0, 1'b0, 32'h2);
        apb_xfer("t4.r3", 1'b0, 32'h40C, 32'h0, 1'b0, 32'h3);
        check("t4.strobes", wr_strobes - s0, 3);

        // psel dropped during REQ of a write: strobe stands, no pready
        s0 = wr_strobes;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40C; pwdata = 32'h5;
        @(posedge clk); #1;
        psel = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (pready) saw_ready = 1'b1;
        end
        check("abort.pready",  {31'b0, saw_ready}, 32'h0);
        check("abort.strobes", wr_strobes - s0,    1);
        check("abort.reg3",    regs[3],            32'h5);
        check("abort.prdata",  prdata,             32'h3);

        // Reset asserted during CAPT of a read
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h408;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("t5.prdata",    prdata,              32'h0);
        check("t5.pready",    {31'b0, pready},     32'h0);
        check("t5.pslverr",   {31'b0, pslverr},    32'h0);
        check("t5.reg_addr",  reg_addr,            32'h0);
        check("t5.reg_wr_en", {31'b0, reg_wr_en},  32'h0);
        check("t5.reg_wdata", reg_wdata,           32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        last_rd = '0;
        @(posedge clk); #1;
        apb_xfer("t5.rd", 1'b0, 32'h408, 32'h0, 1'b0, 32'h0);

        // Statistics mix: 5 writes, 1 read (above), 1 error
        for (int i = 0; i < 5; i++) begin
            apb_xfer($sformatf("t6.w%0d", i), 1'b1, BASE + 32'(4 * (i % 4)),
                     32'(i + 16), 1'b0, 32'h0);
        end
        apb_xfer("t6.err", 1'b0, 32'h500, 32'h0, 1'b1, 32'h0);
        check("t6.reg0", regs[0], 32'd20);
        check("t6.reg1", regs[1], 32'd17);
`ifdef REG_BRIDGE_STATS_EN
        check("t6.stat_wr",  {30'b0, stat_wr},  32'd3);
        check("t6.stat_rd",  {30'b0, stat_rd},  32'd1);
        check("t6.stat_err", {30'b0, stat_err}, 32'd1);
`endif

        check("end.multi_strobe", multi_strobe, 0);
        check("end.sb_empty",     sb.size(),    0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
